// File: rtl/multiport_ram_clr_if.sv
// multiport_ram_clr_if: bus bundle for the multiport clearable RAM
interface multiport_ram_clr_if #(
   parameter int ADDRESS_WIDTH = 13,
   parameter int DATA_WIDTH    = 64,
   parameter int READ_PORTS    = 2
);
   logic                                CLR_Start;
   logic                                BUSY;
   logic                                WR_Enable;
   logic [DATA_WIDTH/8-1:0]             WR_Mask;
   logic [ADDRESS_WIDTH-1:0]            address_WR;
   logic [DATA_WIDTH-1:0]               dataIn;
   logic [READ_PORTS-1:0]               RD_Enable;
   logic [READ_PORTS*ADDRESS_WIDTH-1:0] address_RD;
   logic [READ_PORTS*DATA_WIDTH-1:0]    dataOut;
   logic [READ_PORTS-1:0]               RD_Valid;
   modport master (
      output CLR_Start, WR_Enable, WR_Mask, address_WR, dataIn, RD_Enable, address_RD,
      input  BUSY, dataOut, RD_Valid
   );
   modport slave (
      input  CLR_Start, WR_Enable, WR_Mask, address_WR, dataIn, RD_Enable, address_RD,
      output BUSY, dataOut, RD_Valid
   );
endinterface

// File: rtl/multiport_ram_clr.sv
// multiport_ram_clr: N-read, byte-masked single-write RAM with a sequential clear engine
module multiport_ram_clr #(
   parameter int ADDRESS_WIDTH = 13,
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 2**ADDRESS_WIDTH,
   parameter int READ_PORTS    = 2
) (
   input logic                CLK,
   input logic                RST,
   multiport_ram_clr_if.slave bus
);
   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int NB = DATA_WIDTH / 8;
   localparam int RP = READ_PORTS;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t           state, state_n;
   logic [AW:0]      clr_addr, clr_addr_n;
   logic [DW-1:0]    mem [DEPTH];
   logic             wr_ok;
   logic [AW-1:0]    rd_addr [RP];
   logic [DW-1:0]    rd_word [RP];
   logic [RP*DW-1:0] dout;
   logic [RP-1:0]    valid;
   assign bus.BUSY     = state == CLEAR;
   assign bus.dataOut  = dout;
   assign bus.RD_Valid = valid;
   assign wr_ok = state == IDLE && !RST && bus.WR_Enable && ({1'b0, bus.address_WR} < DEPTH_W);
   for (genvar g = 0; g < RP; g++) begin : g_addr
      assign rd_addr[g] = bus.address_RD[g*AW +: AW];
   end
   // state register: reset restarts the clear from word 0
   always_ff @(posedge CLK)
      if (RST) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_n;
         clr_addr <= clr_addr_n;
      end
   // next state: walk the clear counter, leave CLEAR after the last word; CLR_Start only honoured in IDLE
   always_comb begin
      state_n    = state;
      clr_addr_n = clr_addr;
      if (state == CLEAR) begin
         clr_addr_n = clr_addr + 1'b1;
         if (clr_addr == LAST) state_n = IDLE;
      end else if (bus.CLR_Start) begin
         state_n    = CLEAR;
         clr_addr_n = '0;
      end
   end
   // memory array: one word zeroed per clear cycle, otherwise byte-masked writes
   always_ff @(posedge CLK)
      if (!RST) begin
         if (state == CLEAR) mem[clr_addr[AW-1:0]] <= '0;
         else if (wr_ok)
            for (int b = 0; b < NB; b++)
               if (bus.WR_Mask[b]) mem[bus.address_WR][8*b +: 8] <= bus.dataIn[8*b +: 8];
      end
   // read words with write-first bypass of the same-cycle write; out-of-range reads give zero
   always_comb begin
      for (int i = 0; i < RP; i++) begin
         rd_word[i] = ({1'b0, rd_addr[i]} < DEPTH_W) ? mem[rd_addr[i]] : '0;
         for (int b = 0; b < NB; b++)
            if (wr_ok && bus.WR_Mask[b] && rd_addr[i] == bus.address_WR)
               rd_word[i][8*b +: 8] = bus.dataIn[8*b +: 8];
      end
   end
   // read ports: register data and a one-cycle valid; data holds when not read or while clearing
   always_ff @(posedge CLK)
      if (RST) begin
         dout  <= '0;
         valid <= '0;
      end else begin
         for (int i = 0; i < RP; i++) begin
            valid[i] <= state == IDLE && bus.RD_Enable[i];
            if (state == IDLE && bus.RD_Enable[i]) dout[i*DW +: DW] <= rd_word[i];
         end
      end
endmodule
